// File: rtl/mux_sequencer_if.sv
// Handshake/control, program-load and select bus between the control FSM
// (master) and the mux sequencer (slave).
interface mux_sequencer_if #(
    parameter int N_STEPS = 6,
    parameter int SEL_C_W = 3,
    parameter int SEL_F_W = 2,
    parameter int SEL_A_W = 2
);
    localparam int AW = $clog2(N_STEPS);
    localparam int PW = 1 + SEL_C_W + SEL_F_W + SEL_A_W;

    logic               start;
    logic               hold;
    logic               abort;
    logic [AW:0]        cfg_len;
    logic               prog_we;
    logic [AW-1:0]      prog_addr;
    logic [PW-1:0]      prog_data;
    logic [SEL_C_W-1:0] sel_const;
    logic [SEL_F_W-1:0] sel_fun;
    logic [SEL_A_W-1:0] sel_acum;
    logic               strobe;
    logic [AW-1:0]      step_idx;
    logic               busy;
    logic               done;

    modport master (
        output start, hold, abort, cfg_len, prog_we, prog_addr, prog_data,
        input  sel_const, sel_fun, sel_acum, strobe, step_idx, busy, done
    );

    modport slave (
        input  start, hold, abort, cfg_len, prog_we, prog_addr, prog_data,
        output sel_const, sel_fun, sel_acum, strobe, step_idx, busy, done
    );
endinterface

// File: rtl/mux_sequencer.sv
// Programmable micro-sequencer: walks a loadable table of mux-select words,
// one step per clock, with start/hold/abort control and busy/done status.
// Every output is registered; the comb logic computes next-cycle values.
module mux_sequencer #(
    parameter int N_STEPS = 6,
    parameter int SEL_C_W = 3,
    parameter int SEL_F_W = 2,
    parameter int SEL_A_W = 2,
    parameter logic [N_STEPS*(1+SEL_C_W+SEL_F_W+SEL_A_W)-1:0] DEFAULT_PROG = 48'h4D_39_26_9D_09_00
) (
    input  logic            clk,
    input  logic            reset,
    mux_sequencer_if.slave  bus
);
    localparam int AW = $clog2(N_STEPS);
    localparam int PW = 1 + SEL_C_W + SEL_F_W + SEL_A_W;
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(N_STEPS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [AW-1:0]      r_step, w_step_nxt;
    logic [AW:0]        r_len, w_len_clamped;
    logic [PW-1:0]      r_prog [N_STEPS];

    logic [SEL_C_W-1:0] r_sel_c, w_sel_c;
    logic [SEL_F_W-1:0] r_sel_f, w_sel_f;
    logic [SEL_A_W-1:0] r_sel_a, w_sel_a;
    logic               r_strobe, w_strobe;
    logic               r_busy, w_busy;
    logic               r_done, w_done;

    logic               w_start_ok, w_held, w_last, w_wr_en;
    logic [PW-1:0]      w_rd_word;

    // Start is only honoured outside RUN and loses to abort.
    assign w_start_ok = bus.start && !bus.abort && (r_state != S_RUN);
    assign w_held     = (r_state == S_RUN) && bus.hold && !bus.abort;
    assign w_last     = ({1'b0, r_step} == (r_len - LEN_ONE));
    // Table writes are dropped while running; out-of-range addresses never match.
    assign w_wr_en    = bus.prog_we && (r_state != S_RUN) && ({1'b0, bus.prog_addr} < LEN_MAX);

    // A write landing on the same edge as start must be visible in step 0.
    assign w_rd_word  = (w_wr_en && (bus.prog_addr == w_step_nxt)) ? bus.prog_data
                                                                  : r_prog[w_step_nxt];

    // Run length clamp: zero means one step, anything too large means the full table.
    always_comb begin
        w_len_clamped = bus.cfg_len;
        if (bus.cfg_len == '0)
            w_len_clamped = LEN_ONE;
        else if (bus.cfg_len > LEN_MAX)
            w_len_clamped = LEN_MAX;
    end

    // State register plus step counter and latched run length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_len   <= LEN_MAX;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            if (w_start_ok)
                r_len <= w_len_clamped;
        end
    end

    // Next-state and next-step selection; abort beats start beats hold.
    always_comb begin
        w_state_nxt = S_IDLE;
        w_step_nxt  = '0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.hold) begin
                    w_state_nxt = S_RUN;
                    w_step_nxt  = r_step;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                    w_step_nxt  = r_step + AW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next-cycle output values; strobe only on the first cycle of a step.
    always_comb begin
        w_sel_c  = '0;
        w_sel_f  = '0;
        w_sel_a  = '0;
        w_strobe = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        if (w_state_nxt == S_RUN) begin
            w_sel_c  = w_rd_word[SEL_F_W+SEL_A_W +: SEL_C_W];
            w_sel_f  = w_rd_word[SEL_A_W +: SEL_F_W];
            w_sel_a  = w_rd_word[0 +: SEL_A_W];
            w_strobe = w_rd_word[PW-1] && !w_held;
            w_busy   = 1'b1;
        end else if (w_state_nxt == S_DONE) begin
            w_done   = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_c  <= '0;
            r_sel_f  <= '0;
            r_sel_a  <= '0;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_sel_c  <= w_sel_c;
            r_sel_f  <= w_sel_f;
            r_sel_a  <= w_sel_a;
            r_strobe <= w_strobe;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    // Program table: reloaded from the default image on reset, written when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_STEPS; k++)
                r_prog[k] <= DEFAULT_PROG[k*PW +: PW];
        end else if (w_wr_en) begin
            r_prog[bus.prog_addr] <= bus.prog_data;
        end
    end

    assign bus.sel_const = r_sel_c;
    assign bus.sel_fun   = r_sel_f;
    assign bus.sel_acum  = r_sel_a;
    assign bus.strobe    = r_strobe;
    assign bus.step_idx  = r_step;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_mux_sequencer.sv
// Directed bench for mux_sequencer: hand-computed select tables per step.
module tb_mux_sequencer;
    localparam int N_STEPS = 6;
    localparam int SEL_C_W = 3;
    localparam int SEL_F_W = 2;
    localparam int SEL_A_W = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux_sequencer_if #(.N_STEPS(N_STEPS), .SEL_C_W(SEL_C_W), .SEL_F_W(SEL_F_W), .SEL_A_W(SEL_A_W)) bus ();

    mux_sequencer #(.N_STEPS(N_STEPS), .SEL_C_W(SEL_C_W), .SEL_F_W(SEL_F_W), .SEL_A_W(SEL_A_W),
                    .DEFAULT_PROG(48'h4D_39_26_9D_09_00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Expected (const, fun, acum, strobe) per step of the default program.
    int exp_c [6] = '{0, 0, 1, 2, 3, 4};
    int exp_f [6] = '{0, 2, 3, 1, 2, 3};
    int exp_a [6] = '{0, 1, 1, 2, 1, 1};
    int exp_s [6] = '{0, 0, 1, 0, 0, 0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input int f, input int a, input int s,
                       input int idx, input int bsy, input int dn);
        logic [12:0] obs, expv;
        obs  = {bus.sel_const, bus.sel_fun, bus.sel_acum, bus.strobe, bus.step_idx, bus.busy, bus.done};
        expv = {3'(c), 2'(f), 2'(a), 1'(s), 3'(idx), 1'(bsy), 1'(dn)};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed={c,f,a,s,idx,busy,done}=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Caller sets start (and cfg_len); walks len steps then checks the done cycle.
    task automatic run_check(input string tag, input int len, input bit keep);
        for (int i = 0; i < len; i++) begin
            tick();
            if (!keep) begin
                bus.start   = 1'b0;
                bus.prog_we = 1'b0;
            end
            chk($sformatf("%s_step%0d", tag, i), exp_c[i], exp_f[i], exp_a[i], exp_s[i], i, 1, 0);
        end
        tick();
        chk({tag, "_done"}, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.start = 0; bus.hold = 0; bus.abort = 0; bus.cfg_len = 4'd6;
        bus.prog_we = 0; bus.prog_addr = '0; bus.prog_data = '0;
        reset = 1'b1;
        repeat (2) tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();
        chk_idle("post_reset_idle");

        // 1: full default run
        bus.start = 1;
        run_check("t1", 6, 0);
        tick();
        chk_idle("t1_idle");

        // 2: hold three cycles at step 2
        bus.start = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.start = 0;
            chk($sformatf("t2_step%0d", i), exp_c[i], exp_f[i], exp_a[i], exp_s[i], i, 1, 0);
        end
        bus.hold = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t2_held%0d", i), 1, 3, 1, 0, 2, 1, 0);
        end
        bus.hold = 0;
        for (int i = 3; i < 6; i++) begin
            tick();
            chk($sformatf("t2_step%0d", i), exp_c[i], exp_f[i], exp_a[i], exp_s[i], i, 1, 0);
        end
        tick();
        chk("t2_done", 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk_idle("t2_idle");

        // 3: abort at step 3
        bus.start = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.start = 0;
            chk($sformatf("t3_step%0d", i), exp_c[i], exp_f[i], exp_a[i], exp_s[i], i, 1, 0);
        end
        bus.abort = 1;
        tick();
        chk_idle("t3_aborted");
        bus.abort = 0;
        tick();
        chk_idle("t3_no_done");
        bus.abort = 1; bus.start = 1;
        tick();
        chk_idle("t3_abort_beats_start");
        bus.abort = 0;
        run_check("t3_rerun", 6, 0);
        tick();
        chk_idle("t3_idle");

        // hold outside RUN does nothing
        bus.hold = 1;
        tick();
        chk_idle("hold_in_idle");
        bus.hold = 0;

        // 4: length clamping
        bus.cfg_len = 4'd0; bus.start = 1;
        run_check("t4_len0", 1, 0);
        tick();
        chk_idle("t4_len0_idle");
        bus.cfg_len = 4'd9; bus.start = 1;
        run_check("t4_len9", 6, 0);
        tick();
        chk_idle("t4_len9_idle");
        bus.cfg_len = 4'd3; bus.start = 1;
        run_check("t4_len3", 3, 0);
        tick();
        chk_idle("t4_len3_idle");

        // 6: start held high -> back-to-back runs through DONE
        bus.cfg_len = 4'd6; bus.start = 1;
        run_check("t6_a", 6, 1);
        run_check("t6_b", 6, 1);
        run_check("t6_c", 6, 0);
        tick();
        chk_idle("t6_idle");

        // 5: writes dropped while busy, accepted when idle
        bus.start = 1;
        tick();
        bus.start = 0;
        chk("t5_busy_step0", 0, 0, 0, 0, 0, 1, 0);
        bus.prog_we = 1; bus.prog_addr = 3'd1; bus.prog_data = 8'hFF;
        tick();
        bus.prog_we = 0;
        chk("t5_busy_step1", 0, 2, 1, 0, 1, 1, 0);
        for (int i = 2; i < 6; i++) begin
            tick();
            chk($sformatf("t5_busy_step%0d", i), exp_c[i], exp_f[i], exp_a[i], exp_s[i], i, 1, 0);
        end
        tick();
        chk("t5_busy_done", 0, 0, 0, 0, 0, 0, 1);
        bus.prog_we = 1; bus.prog_addr = 3'd1; bus.prog_data = 8'hFF;
        tick();
        bus.prog_we = 0;
        chk_idle("t5_write_idle");
        bus.prog_we = 1; bus.prog_addr = 3'd6; bus.prog_data = 8'hFF;
        tick();
        bus.prog_we = 0;
        chk_idle("t5_oob_write");
        exp_c[1] = 7; exp_f[1] = 3; exp_a[1] = 3; exp_s[1] = 1;
        bus.start = 1;
        run_check("t5_new", 6, 0);
        tick();
        chk_idle("t5_idle");

        // write and start on the same edge: step 0 uses the new word
        bus.prog_we = 1; bus.prog_addr = 3'd0; bus.prog_data = 8'hA6;
        bus.start = 1;
        exp_c[0] = 2; exp_f[0] = 1; exp_a[0] = 2; exp_s[0] = 1;
        run_check("t5_wr_start", 6, 0);
        tick();
        chk_idle("t5_wr_start_idle");

        // reset mid-run clears outputs at once and restores the default table
        bus.start = 1;
        tick();
        bus.start = 0;
        tick();
        tick();
        chk("rst_pre", 1, 3, 1, 1, 2, 1, 0);
        reset = 1'b1;
        #1;
        chk_idle("rst_async");
        tick();
        reset = 1'b0;
        chk_idle("rst_released");
        exp_c[0] = 0; exp_f[0] = 0; exp_a[0] = 0; exp_s[0] = 0;
        exp_c[1] = 0; exp_f[1] = 2; exp_a[1] = 1; exp_s[1] = 0;
        bus.start = 1;
        run_check("rst_rerun", 6, 0);
        tick();
        chk_idle("rst_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
